free_list: RTL and testbench
============================

# free_list

Circular physical-register free list for the N-way rename stage. At dispatch it hands out up to `N_WAY` free physical tags per cycle; the map table consumes these as `pr_freelist`. At retire it takes back the old tags (T_old) released by the ROB. On `branch_haz` it restores itself in one cycle, in step with the map table's reload from the architectural map.

## Interface
- `N_WAY`, 2: dispatch/retire width.
- `N_PR`, 64: number of physical tags. Valid tags are 1..`N_PR`; tag 0 means "no tag".
- `N_ARCH`, 32: architectural registers. Tags 1..`N_ARCH` are architectural at reset, and tag 1 is x0.
- `CDB_BITS`, 7: tag width. Must satisfy 2^`CDB_BITS` > `N_PR`.
- `DEPTH`, `N_PR`-`N_ARCH` = 32: buffer entries. Must be a power of two.
- `clock` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `dis_req` input [`N_WAY`]: slot n needs a new tag (valid and dest!=0).
- `ret_valid` input [`N_WAY`]: slot n retires an instruction that was allocated a tag.
- `ret_told` input [`N_WAY`][`CDB_BITS`]: T_old of retiring slot n.
- `branch_haz` input 1: mispredict recovery. Discard all in-flight allocations.
- `pr_freelist` output [`N_WAY`][`CDB_BITS`]: granted tag per slot, 0 if none.
- `free_count` output [$clog2(`DEPTH`+1)]: registered count of free tags.
- `empty` output 1: `free_count`==0.

## Operation
- **State**
  - `buf[DEPTH]` holds tags.
  - `head` is the next tag to grant.
  - `rptr` is the retire/enqueue pointer.
  - `free_count` is a registered count.
  - Invariant: entries `rptr`..`head`-1 are in-flight allocations and `head`..`head`+`free_count`-1 are free. In-flight plus free always equals `DEPTH`, so the enqueue slot is always `rptr`.
- **Reset:** `buf[i]`=`N_ARCH`+1+i (33..64), `head`=0, `rptr`=0, `free_count`=`DEPTH`.
- **Grant (combinational)**
  - Requesting slots are served in ascending slot order.
  - The k-th requester (k=0,1,..) receives `buf[head+k]` if k < `free_count`, else 0.
  - Non-requesting slots output 0.
  - Grants are partial-prefix: if requests exceed `free_count`, only the lowest-numbered requesters receive tags.
  - `g` = number of nonzero grants.
- **Retire (sequential)**
  - For each lane n in ascending order with `ret_valid[n]` and `ret_told[n]`>1: write `buf[rptr+m]` <= `ret_told[n]`, where m is the count of accepted lanes below n.
  - `r` = accepted lanes.
  - Lanes with T_old 0 or 1 (x0 mapping) are ignored entirely and do not advance `rptr`.
- **Normal update:**
  - `head` += `g`
  - `rptr` += `r`
  - `free_count` <= `free_count` - `g` + `r`
  - All pointers wrap modulo `DEPTH`.
- **Recovery (`branch_haz`=1)**
  - Retire lanes of that cycle are applied first, i.e. buffer writes and `rptr` += `r`.
  - Then `head` <= `rptr`+`r` and `free_count` <= `DEPTH`.
  - `dis_req` in that cycle is ignored for state purposes: `head` is not advanced by `g`.
  - Grants are still driven combinationally; the map table discards them during recovery.
- **Protocol errors:** more retires than in-flight allocations, or `free_count` exceeding `DEPTH`, must never occur. The bench asserts on them; the RTL need not handle them.

## Timing
- Grant latency is 0 cycles. `pr_freelist` is a function of registered `head`/`free_count` plus `dis_req` only; there is no path from `ret_*`.
- A tag freed at retire in cycle t is grantable at the earliest in cycle t+1; same-cycle bypass is not permitted.
- `free_count`, `empty` and all pointers update at `posedge clock`.
- **Reset values:** `free_count`=`DEPTH`, `empty`=0. `pr_freelist` = `buf[0..]` for requesting slots (33, 34 with both requesting).
- **Full (`free_count`=`DEPTH`):** retires cannot arrive, since there are no in-flight allocations.
- **Empty:** all grants are 0 and `head` holds. A retire in the same cycle raises `free_count` for the next cycle.
- **Wrap:** `head`/`rptr` roll from `DEPTH`-1 to 0 with no bubble. A grant pair may straddle the wrap.
- Reset asserted mid-operation overrides `branch_haz`, retire and dispatch, and reinstates the reset contents.

## Test plan
- **Reset and first grant:** reset, then `dis_req`=2'b11 → `pr_freelist`={34,33} (slot1, slot0). Next cycle `free_count`=30.
- **Single request:** `dis_req`=2'b10 after reset → slot1=33, slot0=0. Then `dis_req`=2'b01 → slot0=34.
- **Exhaust and wrap:** 16 cycles of 2'b11 → tags 33..64 and `empty`=1. A further 2'b11 → both 0 and `head` unchanged. Retire T_old 5,7 with 2'b11 requested → grants 0 that cycle, `free_count`=2, then 5,7 next cycle.
- **Partial grant:** `free_count`=1 with 2'b11 → slot0 gets tag, slot1 0. `free_count`=0 next cycle.
- **Recovery:** from reset allocate 33..38, then `branch_haz` with retire T_old=3 in the same cycle. Next cycle `free_count`=32 and 2'b11 → 34,35. After 31 further grants, tag 3 appears.
- **Filter and reset:** retire with T_old=1 → `rptr`/`free_count` unchanged. Reset during `branch_haz` → reset contents, `free_count`=32.

Source files
------------

// File: rtl/free_list.sv
// free_list: circular physical-register free list for the N-way rename stage.
// Grants up to N_WAY free tags per cycle at dispatch, takes back T_old tags at
// retire, and restores itself in one cycle on a branch hazard.
module free_list #(
   parameter int unsigned N_WAY    = 2,
   parameter int unsigned N_PR     = 64,
   parameter int unsigned N_ARCH   = 32,
   parameter int unsigned CDB_BITS = 7,
   parameter int unsigned DEPTH    = N_PR - N_ARCH
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [N_WAY-1:0]                   dis_req,
   input  logic [N_WAY-1:0]                   ret_valid,
   input  logic [N_WAY-1:0][CDB_BITS-1:0]     ret_told,
   input  logic                               branch_haz,
   output logic [N_WAY-1:0][CDB_BITS-1:0]     pr_freelist,
   output logic [$clog2(DEPTH+1)-1:0]         free_count,
   output logic                               empty
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned LANE_W = $clog2(N_WAY + 1);

   // Buffer entries rptr..head-1 are in flight; head..head+free_count-1 are free.
   logic [CDB_BITS-1:0]               r_buf [DEPTH];
   logic [PTR_W-1:0]                  r_head;
   logic [PTR_W-1:0]                  r_rptr;
   logic [CNT_W-1:0]                  r_free_count;
   logic                              r_empty;

   logic [N_WAY-1:0][CDB_BITS-1:0]    w_grant;
   logic [LANE_W-1:0]                 w_g;
   logic [N_WAY-1:0]                  w_we;
   logic [N_WAY-1:0][PTR_W-1:0]       w_widx;
   logic [LANE_W-1:0]                 w_r;
   logic [PTR_W-1:0]                  w_rptr_nxt;
   logic [PTR_W-1:0]                  w_head_nxt;
   logic [CNT_W-1:0]                  w_free_count_nxt;

   // Grant: k-th requesting slot gets buf[head+k] while k < free_count.
   always_comb begin
      w_grant = '0;
      w_g     = '0;
      for (int n = 0; n < N_WAY; n++) begin
         if (dis_req[n] && (CNT_W'(w_g) < r_free_count)) begin
            w_grant[n] = r_buf[PTR_W'(r_head + PTR_W'(w_g))];
            w_g        = w_g + LANE_W'(1);
         end
      end
   end

   // Retire: compact accepted lanes (T_old > 1) onto consecutive slots from rptr.
   always_comb begin
      w_we   = '0;
      w_widx = '0;
      w_r    = '0;
      for (int n = 0; n < N_WAY; n++) begin
         if (ret_valid[n] && (ret_told[n] > CDB_BITS'(1))) begin
            w_we[n]   = 1'b1;
            w_widx[n] = PTR_W'(r_rptr + PTR_W'(w_r));
            w_r       = w_r + LANE_W'(1);
         end
      end
   end

   // Next pointers/count; recovery frees everything after this cycle's retires.
   always_comb begin
      w_rptr_nxt       = PTR_W'(r_rptr + PTR_W'(w_r));
      w_head_nxt       = PTR_W'(r_head + PTR_W'(w_g));
      w_free_count_nxt = CNT_W'(r_free_count - CNT_W'(w_g) + CNT_W'(w_r));
      if (branch_haz) begin
         w_head_nxt       = w_rptr_nxt;
         w_free_count_nxt = CNT_W'(DEPTH);
      end
   end

   // State update; reset reloads tags N_ARCH+1..N_PR in order.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_buf[i] <= CDB_BITS'(N_ARCH + 1 + i);
         end
         r_head       <= '0;
         r_rptr       <= '0;
         r_free_count <= CNT_W'(DEPTH);
         r_empty      <= 1'b0;
      end else begin
         for (int n = 0; n < N_WAY; n++) begin
            if (w_we[n]) begin
               r_buf[w_widx[n]] <= ret_told[n];
            end
         end
         r_head       <= w_head_nxt;
         r_rptr       <= w_rptr_nxt;
         r_free_count <= w_free_count_nxt;
         r_empty      <= (w_free_count_nxt == '0);
      end
   end

   assign pr_freelist = w_grant;
   assign free_count  = r_free_count;
   assign empty       = r_empty;

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and randomized checks of free_list against a
// queue-based model (in-flight queue followed by free queue).
module tb_free_list;

   logic               clock;
   logic               reset;
   logic [1:0]         dis_req;
   logic [1:0]         ret_valid;
   logic [1:0][6:0]    ret_told;
   logic               branch_haz;
   logic [1:0][6:0]    pr_freelist;
   logic [5:0]         free_count;
   logic               empty;

   int n_cmp = 0;
   int n_err = 0;

   int free_q[$];
   int infl_q[$];
   bit model_valid = 0;
   int obs_g [2];
   int exp_g [2];

   free_list #(
      .N_WAY(2), .N_PR(64), .N_ARCH(32), .CDB_BITS(7), .DEPTH(32)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .dis_req     (dis_req),
      .ret_valid   (ret_valid),
      .ret_told    (ret_told),
      .branch_haz  (branch_haz),
      .pr_freelist (pr_freelist),
      .free_count  (free_count),
      .empty       (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      free_q.delete();
      infl_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(33 + i);
   endtask

   // One clock cycle: drive at negedge, compare settled outputs, advance model at posedge.
   task automatic cycle(input logic [1:0] dis, input logic [1:0] rv,
                        input int t0, input int t1, input logic bh, input logic rst);
      int k;
      int tv [2];
      tv[0] = t0;
      tv[1] = t1;
      @(negedge clock);
      dis_req     = dis;
      ret_valid   = rv;
      ret_told[0] = 7'(t0);
      ret_told[1] = 7'(t1);
      branch_haz  = bh;
      reset       = rst;
      #1;
      k = 0;
      for (int n = 0; n < 2; n++) begin
         exp_g[n] = 0;
         if (dis[n] && k < free_q.size()) begin
            exp_g[n] = free_q[k];
            k++;
         end
         obs_g[n] = int'(pr_freelist[n]);
      end
      if (model_valid) begin
         check("grant0", obs_g[0], exp_g[0]);
         check("grant1", obs_g[1], exp_g[1]);
         check("free_count", int'(free_count), free_q.size());
         check("empty", int'(empty), int'(free_q.size() == 0));
      end
      @(posedge clock);
      if (rst) begin
         model_reset();
         model_valid = 1;
      end else begin
         if (!bh) repeat (k) infl_q.push_back(free_q.pop_front());
         for (int n = 0; n < 2; n++) begin
            if (rv[n] && tv[n] > 1) begin
               if (infl_q.size() == 0) begin
                  n_err++;
                  $display("FAIL protocol: retire with no in-flight allocation (t=%0t)", $time);
               end else begin
                  void'(infl_q.pop_front());
               end
               free_q.push_back(tv[n]);
            end
         end
         if (bh) begin
            free_q = {infl_q, free_q};
            infl_q.delete();
         end
         if (free_q.size() > 32) begin
            n_err++;
            $display("FAIL protocol: free count %0d above depth", free_q.size());
         end
      end
   endtask

   initial begin
      int t [2];
      int acc;
      logic [1:0] rv;
      dis_req    = '0;
      ret_valid  = '0;
      ret_told   = '0;
      branch_haz = 1'b0;
      reset      = 1'b1;

      // Reset and first grant
      cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      #1;
      check("reset_fc", int'(free_count), 32);
      check("reset_empty", int'(empty), 0);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("first_g0", obs_g[0], 33);
      check("first_g1", obs_g[1], 34);
      #1 check("first_fc", int'(free_count), 30);

      // Single requests
      cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      cycle(2'b10, 2'b00, 0, 0, 1'b0, 1'b0);
      check("single_g0", obs_g[0], 0);
      check("single_g1", obs_g[1], 33);
      cycle(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
      check("single_next_g0", obs_g[0], 34);

      // Exhaust, empty, retire into empty list
      cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("exhaust_last_g1", obs_g[1], 64);
      #1 check("exhaust_empty", int'(empty), 1);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("empty_g0", obs_g[0], 0);
      check("empty_g1", obs_g[1], 0);
      cycle(2'b11, 2'b11, 5, 7, 1'b0, 1'b0);
      check("nobypass_g0", obs_g[0], 0);
      check("nobypass_g1", obs_g[1], 0);
      #1 check("retire_fc", int'(free_count), 2);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("wrap_g0", obs_g[0], 5);
      check("wrap_g1", obs_g[1], 7);

      // Partial grant
      cycle(2'b00, 2'b01, 9, 0, 1'b0, 1'b0);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("partial_g0", obs_g[0], 9);
      check("partial_g1", obs_g[1], 0);
      #1 check("partial_fc", int'(free_count), 0);

      // Recovery with same-cycle retire
      cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      cycle(2'b11, 2'b01, 3, 0, 1'b1, 1'b0);
      #1 check("recover_fc", int'(free_count), 32);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("recover_g0", obs_g[0], 34);
      check("recover_g1", obs_g[1], 35);
      for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("recover_tag3", obs_g[1], 3);

      // x0/zero filter, then reset overriding branch_haz
      cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      cycle(2'b00, 2'b11, 1, 0, 1'b0, 1'b0);
      #1 check("filter_fc", int'(free_count), 30);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("filter_g0", obs_g[0], 35);
      cycle(2'b11, 2'b01, 40, 0, 1'b1, 1'b1);
      #1 check("rst_bh_fc", int'(free_count), 32);
      cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      check("rst_bh_g0", obs_g[0], 33);
      check("rst_bh_g1", obs_g[1], 34);

      // Randomized traffic
      for (int it = 0; it < 3000; it++) begin
         acc = 0;
         rv  = '0;
         for (int n = 0; n < 2; n++) begin
            t[n] = $urandom_range(0, 64);
            if ($urandom_range(0, 2) != 0) begin
               if (t[n] <= 1) rv[n] = 1'b1;
               else if (acc < infl_q.size()) begin
                  rv[n] = 1'b1;
                  acc++;
               end
            end
         end
         cycle(2'($urandom), rv, t[0], t[1],
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
